ppi_bus_sequencer: RTL and testbench



---
 rtl/ppi_bus_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_ppi_bus_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_bus_sequencer.sv
// Bus-side sequencer for an 8255-style PPI: round-robin arbitration of two
// requesters, timed setup/strobe/hold/recovery cycles, control word after reset.
module ppi_bus_sequencer #(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned STROBE_CYC   = 2,
  parameter int unsigned HOLD_CYC     = 1,
  parameter int unsigned RECOVERY_CYC = 1,
  parameter logic [7:0]  INIT_CW      = 8'h9B
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_write,
  input  logic [1:0] req0_addr,
  input  logic [7:0] req0_wdata,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_write,
  input  logic [1:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic       rsp_write,
  output logic [7:0] rsp_rdata,
  output logic       PPI_CS_N,
  output logic       PPI_RD_N,
  output logic       PPI_WR_N,
  output logic [1:0] PPI_A,
  output logic [7:0] PPI_D_OUT,
  output logic       PPI_D_OE,
  input  logic [7:0] PPI_D_IN
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
  } state_t;

  // Down-counter reload values; a zero count still occupies one cycle.
  localparam logic [7:0] SETUP_LD    = (SETUP_CYC    == 0) ? 8'd0 : 8'(SETUP_CYC    - 1);
  localparam logic [7:0] STROBE_LD   = (STROBE_CYC   == 0) ? 8'd0 : 8'(STROBE_CYC   - 1);
  localparam logic [7:0] HOLD_LD     = (HOLD_CYC     == 0) ? 8'd0 : 8'(HOLD_CYC     - 1);
  localparam logic [7:0] RECOVERY_LD = (RECOVERY_CYC == 0) ? 8'd0 : 8'(RECOVERY_CYC - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic       w_cnt_zero;
  logic       r_init_pending;
  logic       r_rr;          // 0: req0 wins a tie, 1: req1 wins a tie
  logic       r_wr;
  logic       r_id;
  logic       r_is_init;
  logic       w_acc0;
  logic       w_acc1;
  logic       w_grant0;
  logic       w_grant1;
  logic       w_ld_write;
  logic [1:0] w_ld_addr;
  logic [7:0] w_ld_wdata;

  function automatic logic [7:0] cnt_load(input state_t s);
    case (s)
      S_SETUP:   cnt_load = SETUP_LD;
      S_STROBE:  cnt_load = STROBE_LD;
      S_HOLD:    cnt_load = HOLD_LD;
      S_RECOVER: cnt_load = RECOVERY_LD;
      default:   cnt_load = 8'd0;
    endcase
  endfunction

  assign w_cnt_zero = (r_cnt == 8'd0);

  assign w_grant0 = req0_valid && (!req1_valid || !r_rr);
  assign w_grant1 = req1_valid && !w_grant0;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    w_acc0 = 1'b0;
    w_acc1 = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_init_pending) begin
          w_next = S_SETUP;
        end else begin
          w_acc0 = req0_valid && req0_ready;
          w_acc1 = req1_valid && req1_ready;
          if (w_acc0 || w_acc1) w_next = S_SETUP;
        end
      end
      S_SETUP:   if (w_cnt_zero) w_next = S_STROBE;
      S_STROBE:  if (w_cnt_zero) w_next = S_HOLD;
      S_HOLD:    if (w_cnt_zero) w_next = S_RECOVER;
      S_RECOVER: if (w_cnt_zero) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Payload for the access about to start: the init write or the granted request.
  always_comb begin
    w_ld_write = req0_write;
    w_ld_addr  = req0_addr;
    w_ld_wdata = req0_wdata;
    if (r_init_pending) begin
      w_ld_write = 1'b1;
      w_ld_addr  = 2'b11;
      w_ld_wdata = INIT_CW;
    end else if (w_acc1) begin
      w_ld_write = req1_write;
      w_ld_addr  = req1_addr;
      w_ld_wdata = req1_wdata;
    end
  end

  // NOTE: bus outputs are registered from the transition being taken, so each
  // pin changes on the same edge that enters the state it belongs to.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state        <= S_IDLE;
      r_cnt          <= 8'd0;
      r_init_pending <= 1'b1;
      r_rr           <= 1'b0;
      r_wr           <= 1'b0;
      r_id           <= 1'b0;
      r_is_init      <= 1'b0;
      req0_ready     <= 1'b0;
      req1_ready     <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_id         <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_rdata      <= 8'd0;
      PPI_CS_N       <= 1'b1;
      PPI_RD_N       <= 1'b1;
      PPI_WR_N       <= 1'b1;
      PPI_A          <= 2'b00;
      PPI_D_OUT      <= 8'd0;
      PPI_D_OE       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= cnt_load(w_next);
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - 8'd1;
      end

      rsp_valid  <= 1'b0;
      req0_ready <= (w_next == S_IDLE) && !r_init_pending && w_grant0;
      req1_ready <= (w_next == S_IDLE) && !r_init_pending && w_grant1;

      case (r_state)
        S_IDLE: begin
          if (w_next == S_SETUP) begin
            r_wr      <= w_ld_write;
            r_id      <= w_acc1;
            r_is_init <= r_init_pending;
            if (!r_init_pending) r_rr <= w_acc0;
            PPI_CS_N  <= 1'b0;
            PPI_A     <= w_ld_addr;
            PPI_D_OE  <= w_ld_write;
            if (w_ld_write) PPI_D_OUT <= w_ld_wdata;
          end
        end
        S_SETUP: begin
          if (w_next == S_STROBE) begin
            PPI_RD_N <= r_wr;
            PPI_WR_N <= !r_wr;
          end
        end
        S_STROBE: begin
          if (w_next == S_HOLD) begin
            PPI_RD_N <= 1'b1;
            PPI_WR_N <= 1'b1;
            if (!r_is_init) begin
              rsp_valid <= 1'b1;
              rsp_id    <= r_id;
              rsp_write <= r_wr;
              rsp_rdata <= r_wr ? 8'd0 : PPI_D_IN;
            end
          end
        end
        S_HOLD: begin
          if (w_next == S_RECOVER) begin
            PPI_CS_N <= 1'b1;
            PPI_D_OE <= 1'b0;
            if (r_is_init) r_init_pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Directed bench for ppi_bus_sequencer: init write, single accesses, arbitration,
// reset mid-access, and a second instance with non-default timing.
module tb_ppi_bus_sequencer;

  logic       CLK;
  logic       RESET_N;
  logic       req0_valid, req0_ready, req0_write;
  logic [1:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       req1_valid, req1_ready, req1_write;
  logic [1:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       rsp_valid, rsp_id, rsp_write;
  logic [7:0] rsp_rdata;
  logic       PPI_CS_N, PPI_RD_N, PPI_WR_N, PPI_D_OE;
  logic [1:0] PPI_A;
  logic [7:0] PPI_D_OUT, PPI_D_IN;

  logic       b_req0_valid, b_req0_ready, b_req1_ready;
  logic       b_rsp_valid, b_rsp_id, b_rsp_write;
  logic [7:0] b_rsp_rdata;
  logic       b_cs_n, b_rd_n, b_wr_n, b_d_oe;
  logic [1:0] b_a;
  logic [7:0] b_d_out;

  int n_tests = 0;
  int n_fail  = 0;

  ppi_bus_sequencer dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .PPI_CS_N(PPI_CS_N), .PPI_RD_N(PPI_RD_N), .PPI_WR_N(PPI_WR_N), .PPI_A(PPI_A),
    .PPI_D_OUT(PPI_D_OUT), .PPI_D_OE(PPI_D_OE), .PPI_D_IN(PPI_D_IN)
  );

  ppi_bus_sequencer #(
    .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(0), .RECOVERY_CYC(2)
  ) dut_b (
    .CLK(CLK), .RESET_N(RESET_N),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_write(1'b0),
    .req0_addr(2'b00), .req0_wdata(8'h00),
    .req1_valid(1'b0), .req1_ready(b_req1_ready), .req1_write(1'b0),
    .req1_addr(2'b00), .req1_wdata(8'h00),
    .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_write(b_rsp_write), .rsp_rdata(b_rsp_rdata),
    .PPI_CS_N(b_cs_n), .PPI_RD_N(b_rd_n), .PPI_WR_N(b_wr_n), .PPI_A(b_a),
    .PPI_D_OUT(b_d_out), .PPI_D_OE(b_d_oe), .PPI_D_IN(8'h00)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check the strobe exclusion invariant.
  task automatic step();
    @(negedge CLK);
    check("strobe_excl", {7'd0, PPI_RD_N | PPI_WR_N}, 8'd1);
  endtask

  logic [12:0] v_cs, v_wr, v_oe, v_rdy, v_rsp;
  logic [9:0]  vb_cs, vb_wr, vb_rdy;
  logic [6:0]  vr_rd, vr_cs, vr_rdy, vr_rsp;

  initial begin
    v_cs   = 13'b1100001100001;
    v_wr   = 13'b1110011110011;
    v_oe   = 13'b0011110011110;
    v_rdy  = 13'b0000001000000;
    v_rsp  = 13'b0010000000000;
    vb_cs  = 10'b1110000001;
    vb_wr  = 10'b1111000111;
    vb_rdy = 10'b1000000000;
    vr_rd  = 7'b1100111;
    vr_cs  = 7'b1000011;
    vr_rdy = 7'b0000010;
    vr_rsp = 7'b0100000;

    RESET_N    = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 2'd0; req0_wdata = 8'd0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 2'd0; req1_wdata = 8'd0;
    PPI_D_IN   = 8'hEE;
    b_req0_valid = 1'b1;
    repeat (3) @(negedge CLK);

    check("rst_cs_n",  {7'd0, PPI_CS_N}, 8'd1);
    check("rst_rd_n",  {7'd0, PPI_RD_N}, 8'd1);
    check("rst_wr_n",  {7'd0, PPI_WR_N}, 8'd1);
    check("rst_a",     {6'd0, PPI_A}, 8'd0);
    check("rst_d_out", PPI_D_OUT, 8'd0);
    check("rst_d_oe",  {7'd0, PPI_D_OE}, 8'd0);
    check("rst_rsp",   {7'd0, rsp_valid}, 8'd0);
    check("rst_rdy",   {6'd0, req1_ready, req0_ready}, 8'd0);

    // Init write followed by a req0 write of 90 to A=0; second instance runs its init.
    RESET_N = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i != 0) step();
      check("w_cs_n",  {7'd0, PPI_CS_N}, {7'd0, v_cs[i]});
      check("w_wr_n",  {7'd0, PPI_WR_N}, {7'd0, v_wr[i]});
      check("w_rd_n",  {7'd0, PPI_RD_N}, 8'd1);
      check("w_d_oe",  {7'd0, PPI_D_OE}, {7'd0, v_oe[i]});
      check("w_rdy0",  {7'd0, req0_ready}, {7'd0, v_rdy[i]});
      check("w_rdy1",  {7'd0, req1_ready}, 8'd0);
      check("w_rsp_v", {7'd0, rsp_valid}, {7'd0, v_rsp[i]});
      if (i >= 1 && i <= 4) begin
        check("init_a", {6'd0, PPI_A}, 8'd3);
        check("init_d", PPI_D_OUT, 8'h9B);
      end
      if (i >= 7 && i <= 10) begin
        check("w_a", {6'd0, PPI_A}, 8'd0);
        check("w_d", PPI_D_OUT, 8'd90);
      end
      if (i == 10) begin
        check("w_rsp_id",    {7'd0, rsp_id}, 8'd0);
        check("w_rsp_write", {7'd0, rsp_write}, 8'd1);
        check("w_rsp_rdata", rsp_rdata, 8'd0);
      end
      if (i <= 9) begin
        check("b_cs_n", {7'd0, b_cs_n}, {7'd0, vb_cs[i]});
        check("b_wr_n", {7'd0, b_wr_n}, {7'd0, vb_wr[i]});
        check("b_rdy",  {7'd0, b_req0_ready}, {7'd0, vb_rdy[i]});
      end
      if (i == 4) begin
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd0; req0_wdata = 8'd90;
      end
      if (i == 7) req0_valid = 1'b0;
    end

    // req1 read of A=1; PPI drives 110 only while the strobe is low.
    for (int j = 0; j < 7; j++) begin
      if (j != 0) step();
      check("r_rd_n",  {7'd0, PPI_RD_N}, {7'd0, vr_rd[j]});
      check("r_wr_n",  {7'd0, PPI_WR_N}, 8'd1);
      check("r_cs_n",  {7'd0, PPI_CS_N}, {7'd0, vr_cs[j]});
      check("r_d_oe",  {7'd0, PPI_D_OE}, 8'd0);
      check("r_rdy1",  {7'd0, req1_ready}, {7'd0, vr_rdy[j]});
      check("r_rdy0",  {7'd0, req0_ready}, 8'd0);
      check("r_rsp_v", {7'd0, rsp_valid}, {7'd0, vr_rsp[j]});
      if (j >= 2 && j <= 5) check("r_a", {6'd0, PPI_A}, 8'd1);
      if (j == 5) begin
        check("r_rsp_id",    {7'd0, rsp_id}, 8'd1);
        check("r_rsp_write", {7'd0, rsp_write}, 8'd0);
        check("r_rsp_rdata", rsp_rdata, 8'd110);
      end
      if (j == 0) begin
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 2'd1; req1_wdata = 8'd0;
      end
      if (j == 2) begin
        req1_valid = 1'b0;
        PPI_D_IN   = 8'd110;
      end
      if (j == 5) PPI_D_IN = 8'hEE;
      if (j == 6) begin
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd2; req0_wdata = 8'h11;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 2'd1;
      end
    end

    // Both requesters valid: grants alternate 0,1,0,1 every 6 cycles.
    for (int k = 0; k < 24; k++) begin
      step();
      check("a_rdy0",  {7'd0, req0_ready}, {7'd0, (k % 12) == 0});
      check("a_rdy1",  {7'd0, req1_ready}, {7'd0, (k % 12) == 6});
      check("a_cs_n",  {7'd0, PPI_CS_N}, {7'd0, ((k % 6) == 0) || ((k % 6) == 5)});
      check("a_rsp_v", {7'd0, rsp_valid}, {7'd0, (k % 6) == 4});
      if ((k % 6) == 4) begin
        check("a_rsp_id",    {7'd0, rsp_id}, {7'd0, ((k / 6) % 2) == 1});
        check("a_rsp_write", {7'd0, rsp_write}, {7'd0, ((k / 6) % 2) == 0});
        check("a_rsp_rdata", rsp_rdata, (((k / 6) % 2) == 1) ? 8'hEE : 8'h00);
      end
      if (k == 19) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end

    // Reset during the second strobe cycle of a write.
    step();
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 2'd1; req0_wdata = 8'h33;
    step();
    check("x_rdy0", {7'd0, req0_ready}, 8'd1);
    step();
    req0_valid = 1'b0;
    check("x_cs_n_setup", {7'd0, PPI_CS_N}, 8'd0);
    step();
    step();
    check("x_wr_n_strobe", {7'd0, PPI_WR_N}, 8'd0);
    #2 RESET_N = 1'b0;
    #1;
    check("x_cs_n_rst", {7'd0, PPI_CS_N}, 8'd1);
    check("x_wr_n_rst", {7'd0, PPI_WR_N}, 8'd1);
    check("x_d_oe_rst", {7'd0, PPI_D_OE}, 8'd0);
    check("x_a_rst",    {6'd0, PPI_A}, 8'd0);
    @(negedge CLK);
    check("x_no_rsp", {7'd0, rsp_valid}, 8'd0);
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 2'd2;
    RESET_N = 1'b1;
    for (int r = 0; r < 7; r++) begin
      if (r != 0) step();
      check("x_init_cs_n", {7'd0, PPI_CS_N}, {7'd0, !(r >= 1 && r <= 4)});
      check("x_init_wr_n", {7'd0, PPI_WR_N}, {7'd0, !(r == 2 || r == 3)});
      check("x_init_rdy0", {7'd0, req0_ready}, {7'd0, r == 6});
      check("x_init_rsp",  {7'd0, rsp_valid}, 8'd0);
      if (r >= 1 && r <= 4) begin
        check("x_init_a", {6'd0, PPI_A}, 8'd3);
        check("x_init_d", PPI_D_OUT, 8'h9B);
      end
    end
    req0_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
